// File: rtl/vec_ctrl_pkg.sv
// Opcode, ALU-code and ALU_SRC constants plus the packed control word for vec_issue_control.
package vec_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned SRC_W = 2;

    localparam logic [OP_W-1:0] OP_ADD  = 6'h00;
    localparam logic [OP_W-1:0] OP_ADDI = 6'h01;
    localparam logic [OP_W-1:0] OP_SUB  = 6'h02;
    localparam logic [OP_W-1:0] OP_SUBI = 6'h03;
    localparam logic [OP_W-1:0] OP_XOR  = 6'h04;
    localparam logic [OP_W-1:0] OP_XORI = 6'h05;
    localparam logic [OP_W-1:0] OP_MULT = 6'h06;
    localparam logic [OP_W-1:0] OP_SLV  = 6'h07;
    localparam logic [OP_W-1:0] OP_SRV  = 6'h08;
    localparam logic [OP_W-1:0] OP_SCLV = 6'h09;
    localparam logic [OP_W-1:0] OP_SCRV = 6'h0A;
    localparam logic [OP_W-1:0] OP_LW   = 6'h0B;
    localparam logic [OP_W-1:0] OP_SW   = 6'h0C;
    localparam logic [OP_W-1:0] OP_JUMP = 6'h0D;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'h10;
    localparam logic [OP_W-1:0] OP_NOP  = 6'h3F;

    localparam logic [ALU_W-1:0] ALU_ADD   = 4'h0;
    localparam logic [ALU_W-1:0] ALU_SUB   = 4'h1;
    localparam logic [ALU_W-1:0] ALU_MULT  = 4'h2;
    localparam logic [ALU_W-1:0] ALU_XOR   = 4'h3;
    localparam logic [ALU_W-1:0] ALU_ADDV  = 4'h4;
    localparam logic [ALU_W-1:0] ALU_SUBV  = 4'h5;
    localparam logic [ALU_W-1:0] ALU_XORV  = 4'h6;
    localparam logic [ALU_W-1:0] ALU_SLV   = 4'h7;
    localparam logic [ALU_W-1:0] ALU_SRV   = 4'h8;
    localparam logic [ALU_W-1:0] ALU_SCLV  = 4'h9;
    localparam logic [ALU_W-1:0] ALU_SCRV  = 4'hA;
    localparam logic [ALU_W-1:0] ALU_MUX_A = 4'hB;
    localparam logic [ALU_W-1:0] ALU_NOP   = 4'hF;

    localparam logic [SRC_W-1:0] SRC_REG   = 2'b00;
    localparam logic [SRC_W-1:0] SRC_SHIFT = 2'b01;
    localparam logic [SRC_W-1:0] SRC_IMM   = 2'b10;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             branch;
        logic             not_equal;
        logic [ALU_W-1:0] alu_control;
        logic [SRC_W-1:0] alu_src;
    } ctrl_word_t;

    localparam ctrl_word_t NOP_WORD = '{
        reg_write:   1'b0,
        mem_to_reg:  1'b0,
        mem_write:   1'b0,
        branch:      1'b0,
        not_equal:   1'b0,
        alu_control: ALU_NOP,
        alu_src:     SRC_SHIFT
    };

endpackage

// File: rtl/vec_issue_control_if.sv
// Fetch-side and execute-side handshake bundle for vec_issue_control.
interface vec_issue_control_if #(
    parameter int unsigned LANES          = 8,
    parameter int unsigned LANES_PER_BEAT = 2
);
    localparam int unsigned NBEATS = LANES / LANES_PER_BEAT;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [5:0]        op;
    logic              vec;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch;
    logic              not_equal;
    logic [3:0]        alu_control;
    logic [1:0]        alu_src;
    logic [BEAT_W-1:0] beat;
    logic              last;
    logic [LANES-1:0]  lane_mask;
    logic              illegal;

    modport master (
        output in_valid, op, vec, flush, out_ready,
        input  in_ready, out_valid, reg_write, mem_to_reg, mem_write, branch,
               not_equal, alu_control, alu_src, beat, last, lane_mask, illegal
    );

    modport slave (
        input  in_valid, op, vec, flush, out_ready,
        output in_ready, out_valid, reg_write, mem_to_reg, mem_write, branch,
               not_equal, alu_control, alu_src, beat, last, lane_mask, illegal
    );
endinterface

// File: rtl/vec_ctrl_decode.sv
// Combinational OP/VEC -> control word, multi-beat and illegal flags.
// Illegal reporting is enabled by defining VEC_ISSUE_ILLEGAL_EN.
module vec_ctrl_decode
    import vec_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic            vec,
    output ctrl_word_t      word_c,
    output logic            multi_c,
    output logic            illegal_c
);

    ctrl_word_t w;
    logic       bad;

    // Opcode table; undefined opcodes and vector forms of scalar-only ops collapse to NOP.
    always_comb begin
        w           = NOP_WORD;
        w.reg_write = 1'b1;
        w.alu_src   = SRC_REG;
        bad         = 1'b0;
        case (op)
            OP_ADD:  w.alu_control = vec ? ALU_ADDV : ALU_ADD;
            OP_ADDI: begin w.alu_control = ALU_ADD; w.alu_src = SRC_IMM; bad = vec; end
            OP_SUB:  w.alu_control = vec ? ALU_SUBV : ALU_SUB;
            OP_SUBI: begin w.alu_control = ALU_SUB; w.alu_src = SRC_IMM; bad = vec; end
            OP_XOR:  w.alu_control = vec ? ALU_XORV : ALU_XOR;
            OP_XORI: begin w.alu_control = vec ? ALU_XORV : ALU_XOR; w.alu_src = SRC_IMM; end
            OP_MULT: begin w.alu_control = ALU_MULT; bad = vec; end
            OP_SLV:  begin w.alu_control = ALU_SLV;  w.alu_src = SRC_SHIFT; end
            OP_SRV:  begin w.alu_control = ALU_SRV;  w.alu_src = SRC_SHIFT; end
            OP_SCLV: begin w.alu_control = ALU_SCLV; w.alu_src = SRC_SHIFT; end
            OP_SCRV: begin w.alu_control = ALU_SCRV; w.alu_src = SRC_SHIFT; end
            OP_LW:   begin w.mem_to_reg = 1'b1; w.alu_control = ALU_ADD; end
            OP_SW:   begin w.reg_write = 1'b0; w.mem_write = 1'b1; w.alu_control = ALU_MUX_A; end
            OP_JUMP: begin
                w.reg_write = 1'b0; w.branch = 1'b1; w.not_equal = 1'b1;
                w.alu_control = ALU_ADD; bad = vec;
            end
            OP_BEQ:  begin w.reg_write = 1'b0; w.branch = 1'b1; w.alu_control = ALU_ADD; bad = vec; end
            OP_NOP:  w = NOP_WORD;
            default: bad = 1'b1;
        endcase
        if (bad) begin
            w = NOP_WORD;
        end
    end

    assign word_c  = w;
    assign multi_c = !bad && (((w.alu_control >= ALU_ADDV) && (w.alu_control <= ALU_SCRV)) ||
                              (((op == OP_LW) || (op == OP_SW)) && vec));

`ifdef VEC_ISSUE_ILLEGAL_EN
    assign illegal_c = bad;
`else
    assign illegal_c = 1'b0;
`endif

endmodule

// File: rtl/vec_issue_control.sv
// Registered issue stage: decodes one instruction and sequences it over lane-group beats.
// Optional illegal-opcode flag: VEC_ISSUE_ILLEGAL_EN (see vec_ctrl_decode).
module vec_issue_control
    import vec_ctrl_pkg::*;
#(
    parameter int unsigned LANES          = 8,
    parameter int unsigned LANES_PER_BEAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    vec_issue_control_if.slave  bus
);

    localparam int unsigned NBEATS = LANES / LANES_PER_BEAT;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;

    localparam logic [LANES-1:0]  GRP_MASK  = LANES'({LANES_PER_BEAT{1'b1}});
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    function automatic logic [LANES-1:0] beat_mask(input logic [BEAT_W-1:0] b);
        return GRP_MASK << (LANES_PER_BEAT * 32'(b));
    endfunction

    logic [0:0]        state_q, state_d;
    ctrl_word_t        word_q, word_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last_q, last_d;
    logic [LANES-1:0]  mask_q, mask_d;
    logic              ill_q, ill_d;

    ctrl_word_t        dec_word;
    logic              dec_multi;
    logic              dec_ill;
    logic              in_ready_c;
    logic              accept_c;

    vec_ctrl_decode u_decode (
        .op        (bus.op),
        .vec       (bus.vec),
        .word_c    (dec_word),
        .multi_c   (dec_multi),
        .illegal_c (dec_ill)
    );

    assign in_ready_c = !bus.flush && ((state_q == ST_EMPTY) || (bus.out_ready && last_q));
    assign accept_c   = bus.in_valid && in_ready_c;

    // Next-state: flush beats accept, accept beats advance, stall holds everything.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        beat_d  = beat_q;
        last_d  = last_q;
        mask_d  = mask_q;
        ill_d   = ill_q;
        if (bus.flush || (!accept_c && (state_q == ST_BUSY) && bus.out_ready && last_q)) begin
            state_d = ST_EMPTY;
            word_d  = NOP_WORD;
            beat_d  = '0;
            last_d  = 1'b0;
            mask_d  = '0;
            ill_d   = 1'b0;
        end else if (accept_c) begin
            state_d = ST_BUSY;
            word_d  = dec_word;
            beat_d  = '0;
            last_d  = !dec_multi || (NBEATS == 1);
            mask_d  = dec_multi ? beat_mask('0) : LANES'(1);
            ill_d   = dec_ill;
        end else if ((state_q == ST_BUSY) && bus.out_ready) begin
            beat_d  = beat_q + BEAT_W'(1);
            last_d  = (beat_d == LAST_BEAT);
            mask_d  = beat_mask(beat_d);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            word_q  <= NOP_WORD;
            beat_q  <= '0;
            last_q  <= 1'b0;
            mask_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = (state_q == ST_BUSY);
    assign bus.reg_write   = word_q.reg_write;
    assign bus.mem_to_reg  = word_q.mem_to_reg;
    assign bus.mem_write   = word_q.mem_write;
    assign bus.branch      = word_q.branch;
    assign bus.not_equal   = word_q.not_equal;
    assign bus.alu_control = word_q.alu_control;
    assign bus.alu_src     = word_q.alu_src;
    assign bus.beat        = beat_q;
    assign bus.last        = last_q;
    assign bus.lane_mask   = mask_q;
    assign bus.illegal     = ill_q;

endmodule

// File: doc/vec_issue_control.md
# vec_issue_control

Registered, pipelined successor to the single-cycle control decoder. Decodes a 6-bit opcode plus vector flag into the datapath control word and sequences vector instructions over a configurable number of lane-group beats, with a valid/ready handshake on both sides, a flush input, and optional illegal-opcode detection. Sits between instruction fetch/decode and the execute stage.

## Interface
- LANES, 8, total vector lanes
- LANES_PER_BEAT, 2, lanes processed per issued beat; LANES must be a multiple of it
- NBEATS (localparam), LANES/LANES_PER_BEAT
- BEAT_W (localparam), max(1, $clog2(NBEATS))

- CLK  in  1  clock
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  instruction present
- IN_READY  out  1  instruction accepted this cycle when high with IN_VALID
- OP  in  6  opcode
- VEC  in  1  vector-form flag
- FLUSH  in  1  discard in-flight instruction
- OUT_VALID  out  1  control word valid
- OUT_READY  in  1  execute stage consumes the current beat
- REG_WRITE, MEM_TO_REG, MEM_WRITE, BRANCH, NOT_EQUAL  out  1 each  control bits
- ALU_CONTROL  out  4  ALU operation
- ALU_SRC  out  2  00 register, 01 shift, 10 sign-extended immediate
- BEAT  out  BEAT_W  current beat index
- LAST  out  1  current beat is final beat of the instruction
- LANE_MASK  out  LANES  active lanes this beat
- ILLEGAL  out  1  opcode undefined

## Operation
- Opcodes: ADD 00, ADDI 01, SUB 02, SUBI 03, XOR 04, XORI 05, MULT 06, SLV 07, SRV 08, SCLV 09, SCRV 0A, LW 0B, SW 0C, JUMP 0D, BEQ 10, NOP 3F.
- ALU codes: ADD 0, SUB 1, MULT 2, XOR 3, ADDV 4, SUBV 5, XORV 6, SLV 7, SRV 8, SCLV 9, SCRV A, MUX_A B, NOP F.
- Control word per opcode: ADD/SUB/XOR use V-variant ALU codes when VEC=1, ALU_SRC=00; ADDI/SUBI ALU_SRC=10 scalar only; XORI ALU_SRC=10, XORV when VEC=1; MULT 00; shifts ALU_SRC=01; all above REG_WRITE=1. LW: REG_WRITE, MEM_TO_REG, ADD. SW: MEM_WRITE, MUX_A. JUMP: BRANCH=1, NOT_EQUAL=1, ADD. BEQ: BRANCH=1, ADD. NOP: NOP word.
- NOP word: all bits 0, ALU_CONTROL=F, ALU_SRC=01.
- Multi-beat ops (NBEATS beats): any op whose ALU code is 4..A, plus LW/SW with VEC=1. All others single-beat.
- LANE_MASK: multi-beat, bits [BEAT*LANES_PER_BEAT +: LANES_PER_BEAT] set; single-beat, bit 0 only.
- FSM: EMPTY (OUT_VALID=0), BUSY (OUT_VALID=1).
- IN_READY = !FLUSH && (EMPTY || (OUT_READY && LAST)).
- Accept (IN_VALID && IN_READY): load decoded word, BEAT=0, LAST=(single-beat || NBEATS==1), go/stay BUSY.
- BUSY, OUT_READY, !LAST: BEAT+1, LAST set when BEAT+1 == NBEATS-1.
- BUSY, OUT_READY, LAST, no accept: go EMPTY, output register loads NOP word, BEAT=0, mask 0.
- BUSY, !OUT_READY: all outputs held stable.
- FLUSH has priority over everything: next cycle EMPTY with NOP word; no accept during FLUSH.

## Timing
- Reset: OUT_VALID 0, NOP word, BEAT 0, LAST 0, LANE_MASK 0, ILLEGAL 0; IN_READY 1 once RST_N high and FLUSH low.
- Latency: accept at edge N -> OUT_VALID at N+1 with beat 0.
- Throughput: single-beat ops one per cycle back-to-back; vector op occupies NBEATS cycles with OUT_READY held high.
- Reset asserted mid-instruction aborts immediately; no beat is resumed.

## Configuration
- VEC_ISSUE_ILLEGAL_EN defined: undefined opcode or VEC=1 on MULT/ADDI/SUBI/JUMP/BEQ issues single NOP-word beat with ILLEGAL=1.
- Not defined: same cases issue NOP word, ILLEGAL tied 0.

## Structure
- Package vec_ctrl_pkg: opcode and ALU-code constants, ALU_SRC encodings, packed control-word struct, NOP word constant.
- Sub-module vec_ctrl_decode: combinational OP/VEC -> control word, multi-beat flag, illegal flag.

## Test plan
- Reset, then ADD VEC=0 with OUT_READY=1 -> one cycle later OUT_VALID=1, ALU_CONTROL=0, REG_WRITE=1, LAST=1, LANE_MASK=8'h01.
- ADD VEC=1, LANES=8/LPB=2 -> four beats, BEAT 0..3, masks 03,0C,30,C0, LAST only on beat 3, IN_READY high only on beat 3.
- Vector op with OUT_READY low on beat 1 for 3 cycles -> BEAT=1 and mask 0C held, no skipped beat.
- FLUSH on beat 2 with IN_VALID high -> next cycle OUT_VALID=0, NOP word, instruction not accepted that cycle.
- Back-to-back SW then BEQ -> MEM_WRITE=1/ALU_CONTROL=B, then BRANCH=1/NOT_EQUAL=0 on consecutive cycles.
- OP=6'h20 with VEC_ISSUE_ILLEGAL_EN -> ILLEGAL=1, NOP word, single beat; without macro ILLEGAL=0.
